// File: rtl/lo_rx.sv
// rtl/lo_rx.sv - tone receiver: period, peak/trough and lock tracking (optional amplitude trackers under LO_RX_AMP_EN)
module lo_rx #(
    parameter int MID      = 100,
    parameter int HYST     = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    output logic [7:0] period_out,
    output logic [7:0] peak_out,
    output logic [7:0] trough_out,
    output logic       cycle_done,
    output logic       locked
);

    localparam logic [7:0] HI     = 8'(MID + HYST);
    localparam logic [7:0] LO     = 8'(MID - HYST);
    localparam logic [7:0] LOCK_C = 8'(LOCK_CNT);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        ARM   = 2'd1,
        ABOVE = 2'd2,
        BELOW = 2'd3
    } state_t;

    state_t     state, state_nx;
    logic [7:0] cnt;
    logic [7:0] run;
    logic       have_prev;

    logic       is_hi, is_lo, in_cycle;
    logic       rise, done, ovf, match;
    logic [7:0] period_new, pdiff, run_inc;

    assign is_hi    = (sample_in >= HI);
    assign is_lo    = (sample_in <= LO);
    assign in_cycle = (state == ABOVE) || (state == BELOW);

    // Any rising crossing restarts the count and the trackers; only BELOW->ABOVE closes a cycle.
    assign rise = sample_valid && is_hi && ((state == ARM) || (state == BELOW));
    assign done = sample_valid && is_hi && (state == BELOW);
    // A full counter with no cycle-closing crossing means the tone is lost.
    assign ovf  = sample_valid && in_cycle && (cnt == 8'hFF) && !done;

    assign period_new = cnt + 8'd1;
    assign pdiff      = (period_new >= period_out) ? (period_new - period_out)
                                                   : (period_out - period_new);
    // The first cycle after re-acquisition has nothing valid to compare against.
    assign match      = have_prev && (pdiff <= 8'd1);
    assign run_inc    = (run >= LOCK_C) ? run : (run + 8'd1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= HUNT;
        else     state <= state_nx;
    end

    // Crossing detector next-state; only valid samples move it.
    always_comb begin
        state_nx = state;
        if (sample_valid) begin
            case (state)
                HUNT:  if (is_lo) state_nx = ARM;
                ARM:   if (is_hi) state_nx = ABOVE;
                ABOVE: begin
                    if (ovf)        state_nx = HUNT;
                    else if (is_lo) state_nx = BELOW;
                end
                BELOW: begin
                    if (is_hi)    state_nx = ABOVE;
                    else if (ovf) state_nx = HUNT;
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    // Sample counter, period result and lock run tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 8'd0;
            run        <= 8'd0;
            have_prev  <= 1'b0;
            period_out <= 8'd0;
            cycle_done <= 1'b0;
            locked     <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            if (ovf) begin
                cnt       <= 8'd0;
                run       <= 8'd0;
                have_prev <= 1'b0;
                locked    <= 1'b0;
            end else if (rise) begin
                cnt <= 8'd0;
                if (done) begin
                    period_out <= period_new;
                    cycle_done <= 1'b1;
                    have_prev  <= 1'b1;
                    run        <= match ? run_inc : 8'd0;
                    locked     <= match && (run_inc >= LOCK_C);
                end
            end else if (sample_valid && in_cycle) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

`ifdef LO_RX_AMP_EN
    logic [7:0] trk_max, trk_min;

    // Max/min of the cycle in progress; the closing crossing sample seeds the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk_max    <= 8'd0;
            trk_min    <= 8'd0;
            peak_out   <= 8'd0;
            trough_out <= 8'd0;
        end else if (rise) begin
            trk_max <= sample_in;
            trk_min <= sample_in;
            if (done) begin
                peak_out   <= trk_max;
                trough_out <= trk_min;
            end
        end else if (sample_valid && in_cycle) begin
            if (sample_in > trk_max) trk_max <= sample_in;
            if (sample_in < trk_min) trk_min <= sample_in;
        end
    end
`else
    assign peak_out   = 8'd0;
    assign trough_out = 8'd0;
`endif

endmodule

// File: tb/tb_lo_rx.sv
// tb/tb_lo_rx.sv - randomized self-checking bench for lo_rx against a cycle-length reference model
module tb_lo_rx;

    localparam int MID = 100, HYST = 8, LOCK_CNT = 4;
    localparam int HI = MID + HYST, LO = MID - HYST;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic [7:0] period_out, peak_out, trough_out;
    logic       cycle_done, locked;

    lo_rx #(.MID(MID), .HYST(HYST), .LOCK_CNT(LOCK_CNT)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .period_out(period_out), .peak_out(peak_out), .trough_out(trough_out),
        .cycle_done(cycle_done), .locked(locked)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int sine16[16] = '{100,138,171,192,200,192,171,138,100,62,29,8,0,8,29,62};
    int sine8[8]   = '{100,171,200,171,100,29,0,29};

    // Reference: a cycle is the run of valid samples from one rising crossing up to the next.
    bit         m_seen_low, m_in_cycle, m_high, m_prev_valid, m_lock, m_done;
    int         m_len, m_max, m_min, m_prevp, m_streak;
    logic [7:0] m_period, m_peak, m_trough;

    task automatic model_reset();
        m_seen_low = 0; m_in_cycle = 0; m_high = 0; m_prev_valid = 0;
        m_lock = 0; m_done = 0; m_len = 0; m_max = 0; m_min = 0;
        m_prevp = 0; m_streak = 0; m_period = 0; m_peak = 0; m_trough = 0;
    endtask

    task automatic model_sample(input int s);
        int p, d;
        bit rising, match;
        if (!m_in_cycle) begin
            if (!m_seen_low) begin
                if (s <= LO) m_seen_low = 1;
            end else if (s >= HI) begin
                m_in_cycle = 1; m_high = 1; m_len = 1; m_max = s; m_min = s;
            end
        end else begin
            rising = !m_high && (s >= HI);
            if (rising) begin
                p = m_len % 256;
                d = p - m_prevp;
                if (d < 0) d = -d;
                match = m_prev_valid && (d <= 1);
                if (match) begin
                    if (m_streak < LOCK_CNT) m_streak++;
                    m_lock = (m_streak >= LOCK_CNT);
                end else begin
                    m_streak = 0; m_lock = 0;
                end
                m_done = 1; m_period = p[7:0]; m_prevp = p; m_prev_valid = 1;
`ifdef LO_RX_AMP_EN
                m_peak = m_max[7:0]; m_trough = m_min[7:0];
`endif
                m_high = 1; m_len = 1; m_max = s; m_min = s;
            end else if (m_len == 256) begin
                m_seen_low = 0; m_in_cycle = 0; m_streak = 0; m_lock = 0; m_prev_valid = 0;
            end else begin
                if (m_high && s <= LO) m_high = 0;
                m_len++;
                if (s > m_max) m_max = s;
                if (s < m_min) m_min = s;
            end
        end
    endtask

    task automatic step(input int s, input bit v);
        @(negedge clk);
        sample_in = s[7:0];
        sample_valid = v;
        @(posedge clk);
        m_done = 0;
        if (v) model_sample(s);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1; sample_valid = 1; sample_in = 8'd50;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 0; sample_valid = 0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; sample_valid = 1; sample_in = 8'd200;
        @(posedge clk); #1;
        n_checks++;
        if ({period_out, peak_out, trough_out, cycle_done, locked} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset outputs got p=%0d pk=%0d tr=%0d d=%b l=%b want all 0",
                     period_out, peak_out, trough_out, cycle_done, locked);
        end
        @(negedge clk); rst = 0; sample_valid = 0; model_reset();
        for (int i = 0; i < 3; i++) begin
            step(i == 1 ? 0 : 200, 1);
            n_checks++;
            if (cycle_done !== 1'b0 || locked !== 1'b0 || period_out !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_hold got d=%b l=%b p=%0d want 0", cycle_done, locked, period_out);
            end
        end
    endtask

    task automatic test_sine16();
        int nd = 0;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 16; i++) begin
                step(sine16[i], 1);
                n_checks++;
                if (cycle_done !== m_done || locked !== m_lock) begin
                    n_fail++;
                    $display("FAIL sine16 flags got d=%b l=%b want d=%b l=%b", cycle_done, locked, m_done, m_lock);
                end
                if (cycle_done) begin
                    nd++;
                    n_checks++;
                    if (period_out !== 8'd16) begin
                        n_fail++;
                        $display("FAIL sine16 period got %0d want 16", period_out);
                    end
`ifdef LO_RX_AMP_EN
                    n_checks++;
                    if (peak_out !== 8'd200 || trough_out !== 8'd0) begin
                        n_fail++;
                        $display("FAIL sine16 amp got %0d/%0d want 200/0", peak_out, trough_out);
                    end
`endif
                    n_checks++;
                    if (locked !== (nd >= 5)) begin
                        n_fail++;
                        $display("FAIL sine16 lock at done %0d got %b want %b", nd, locked, nd >= 5);
                    end
                end
            end
        end
        n_checks++;
        if (nd != 6) begin
            n_fail++;
            $display("FAIL sine16 done count got %0d want 6", nd);
        end
    endtask

    task automatic test_freq_change();
        int since = -1;
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 8; i++) begin
                step(sine8[i], 1);
                n_checks++;
                if (cycle_done !== m_done || locked !== m_lock || (m_done && period_out !== m_period)) begin
                    n_fail++;
                    $display("FAIL freq flags got d=%b l=%b p=%0d want d=%b l=%b p=%0d",
                             cycle_done, locked, period_out, m_done, m_lock, m_period);
                end
                if (cycle_done && since < 0 && period_out == 8'd8) since = 0;
                else if (cycle_done && since >= 0) since++;
                if (cycle_done && since >= 0 && since <= 4) begin
                    n_checks++;
                    if (locked !== (since == 4)) begin
                        n_fail++;
                        $display("FAIL freq lock after %0d periods got %b want %b", since, locked, since == 4);
                    end
                end
            end
        end
        n_checks++;
        if (since < 4) begin
            n_fail++;
            $display("FAIL freq no relock got %0d periods want >=4", since);
        end
    endtask

    task automatic test_gapped();
        time last = 0;
        int  nd = 0;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 16; i++) begin
                step(sine16[i], 1);
                n_checks++;
                if (cycle_done !== m_done || locked !== m_lock) begin
                    n_fail++;
                    $display("FAIL gapped flags got d=%b l=%b want d=%b l=%b", cycle_done, locked, m_done, m_lock);
                end
                if (cycle_done) begin
                    nd++;
                    n_checks++;
                    if (period_out !== 8'd16 || (nd > 1 && ($time - last) != 320)) begin
                        n_fail++;
                        $display("FAIL gapped period=%0d spacing=%0t want 16/320", period_out, $time - last);
                    end
                    last = $time;
                end
                step($urandom_range(0, 255), 0);
                n_checks++;
                if (cycle_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gapped idle done got %b want 0", cycle_done);
                end
            end
        end
    endtask

    task automatic test_hysteresis();
        int nd = 0;
        apply_reset();
        for (int i = 0; i < 1020; i++) begin
            step(i < 20 ? 100 : 105, 1);
            if (cycle_done) nd++;
        end
        n_checks++;
        if (nd != 0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL hysteresis got dones=%0d locked=%b want 0/0", nd, locked);
        end
    endtask

    task automatic test_overflow();
        int nd = 0;
        apply_reset();
        for (int k = 0; k < 7; k++)
            for (int i = 0; i < 16; i++) step(sine16[i], 1);
        step(200, 1);
        for (int i = 0; i < 299; i++) begin
            step(200, 1);
            if (cycle_done) nd++;
            n_checks++;
            if (locked !== m_lock) begin
                n_fail++;
                $display("FAIL overflow lock at %0d got %b want %b", i, locked, m_lock);
            end
        end
        n_checks++;
        if (nd != 0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow end got dones=%0d locked=%b want 0/0", nd, locked);
        end
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) begin
                step(sine16[(i + 4) % 16], 1);
                n_checks++;
                if (cycle_done !== m_done || (m_done && period_out !== m_period)) begin
                    n_fail++;
                    $display("FAIL overflow reacq got d=%b p=%0d want d=%b p=%0d", cycle_done, period_out, m_done, m_period);
                end
            end
    endtask

    task automatic test_async_reset();
        int nd = 0;
        apply_reset();
        for (int i = 0; i < 53; i++) step(sine16[i % 16], 1);
        #2 rst = 1;
        #1;
        n_checks++;
        if ({period_out, peak_out, trough_out, cycle_done, locked} !== 26'd0) begin
            n_fail++;
            $display("FAIL async reset got p=%0d pk=%0d tr=%0d d=%b l=%b want all 0",
                     period_out, peak_out, trough_out, cycle_done, locked);
        end
        @(negedge clk); rst = 0; model_reset();
        for (int i = 0; i < 40; i++) begin
            step(sine16[(i + 5) % 16], 1);
            if (cycle_done) nd++;
            n_checks++;
            if (cycle_done !== m_done || (m_done && period_out !== m_period)) begin
                n_fail++;
                $display("FAIL async reacq got d=%b p=%0d want d=%b p=%0d", cycle_done, period_out, m_done, m_period);
            end
        end
        n_checks++;
        if (nd != 1) begin
            n_fail++;
            $display("FAIL async reacq dones got %0d want 1", nd);
        end
    endtask

    task automatic test_random();
        int per, s;
        apply_reset();
        for (int k = 0; k < 40; k++) begin
            per = $urandom_range(10, 22);
            for (int i = 0; i < per; i++) begin
                if ($urandom_range(0, 7) == 0)  s = $urandom_range(LO + 1, HI - 1);
                else if (i < per / 2)           s = $urandom_range(HI, 255);
                else                            s = $urandom_range(0, LO);
                step(s, $urandom_range(0, 3) != 0);
                n_checks++;
                if (cycle_done !== m_done || locked !== m_lock ||
                    (m_done && (period_out !== m_period || peak_out !== m_peak || trough_out !== m_trough))) begin
                    n_fail++;
                    $display("FAIL random got d=%b l=%b p=%0d pk=%0d tr=%0d want d=%b l=%b p=%0d pk=%0d tr=%0d",
                             cycle_done, locked, period_out, peak_out, trough_out,
                             m_done, m_lock, m_period, m_peak, m_trough);
                end
            end
        end
    endtask

    initial begin
        rst = 0; sample_in = 0; sample_valid = 0;
        model_reset();
        test_reset();
        test_sine16();
        test_freq_change();
        test_gapped();
        test_hysteresis();
        test_overflow();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
